// File: rtl/key_debouncer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | key_debouncer                                                            |
// | Synchronises and debounces active-low push buttons; per-key level,       |
// | press/release pulses and a press-toggled flag.                           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module key_debouncer #(
  parameter int N_KEYS        = 4,
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int CNT_WIDTH     = 20
) (
  input  logic              clock_50_MHz,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] pressed,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] toggle
);

  localparam logic [CNT_WIDTH-1:0] c_cnt_last = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic [N_KEYS-1:0] r_sync1;
  logic [N_KEYS-1:0] r_sync2;

  // Synchroniser resets to "released" so a key held through reset reads as a press.
  always_ff @(posedge clock_50_MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    logic                 w_sample;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_pressed;
    logic                 r_press_pulse;
    logic                 r_release_pulse;
    logic                 r_toggle;

    assign w_sample = ~r_sync2[i];

    always_ff @(posedge clock_50_MHz or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt           <= '0;
        r_pressed       <= 1'b0;
        r_press_pulse   <= 1'b0;
        r_release_pulse <= 1'b0;
        r_toggle        <= 1'b0;
      end else if (w_sample != r_pressed) begin
        if (r_cnt == c_cnt_last) begin
          r_pressed       <= w_sample;
          r_cnt           <= '0;
          r_press_pulse   <= w_sample;
          r_release_pulse <= ~w_sample;
          r_toggle        <= r_toggle ^ w_sample;
        end else begin
          r_cnt           <= r_cnt + CNT_WIDTH'(1);
          r_press_pulse   <= 1'b0;
          r_release_pulse <= 1'b0;
        end
      end else begin
        // Any agreeing sample restarts the stability window.
        r_cnt           <= '0;
        r_press_pulse   <= 1'b0;
        r_release_pulse <= 1'b0;
      end
    end

    assign pressed[i]       = r_pressed;
    assign press_pulse[i]   = r_press_pulse;
    assign release_pulse[i] = r_release_pulse;
    assign toggle[i]        = r_toggle;
  end

endmodule
`default_nettype wire
